// File: rtl/hc595_pkg.sv
// Shared types, constants and elaboration helpers for the 74HC595 chain controller.
package hc595_pkg;

  localparam int unsigned HC595_BITS_PER_DEV = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SH_LO,
    S_SH_HI,
    S_LATCH,
    S_DONE
  } hc595_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hc595_chain_ctrl_div_tick.sv
// CLK_DIV down-counter: restart reloads it, o_tick marks the last cycle of each period.
module hc595_div_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [7:0] LP_TOP = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= LP_TOP;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= LP_TOP;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy chain of 74HC595s: shift MSB first, latch with RCLK,
// gate OE until a valid image is latched, and compare the QH' return with the old image.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int unsigned N_BITS  = 32,
  parameter int unsigned CLK_DIV = 4,
  parameter bit          AUTO    = 1'b0,
  parameter bit          RB_EN   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_BITS-1:0] i_data,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_oe_en,
  input  logic              i_ser_ret,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_chain_err,
  output logic              o_OE_n,
  output logic              o_SRCLR_n,
  output logic              o_RCLK,
  output logic              o_SER,
  output logic              o_SRCLK
);

  localparam int unsigned    BW      = clog2(N_BITS + 1);
  localparam logic [BW-1:0]  LP_LAST = BW'(N_BITS - 1);
  localparam logic [BW-1:0]  LP_ONE  = BW'(1);

  hc595_state_t      r_state, w_state;
  logic              r_boot, w_boot;
  logic              r_clr_ph, w_clr_ph;
  logic [N_BITS-1:0] r_img, w_img;
  logic [N_BITS-1:0] r_sreg, w_sreg;
  logic [N_BITS-1:0] r_shadow, w_shadow;
  logic [N_BITS-1:0] r_rb, w_rb;
  logic              r_img_valid, w_img_valid;
  logic [BW-1:0]     r_bit, w_bit;
  logic              r_ser, w_ser;
  logic              r_chain_err, w_chain_err;
  logic              w_tick, w_restart;
  logic              w_srclr_n, w_rclk, w_srclk, w_busy, w_done, w_oe_n;

  hc595_div_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  // Reset parks in IDLE with r_boot set, so the first state after release is CLEAR
  // while o_busy stays high throughout.
  always_comb begin
    w_state     = r_state;
    w_boot      = r_boot;
    w_clr_ph    = r_clr_ph;
    w_img       = r_img;
    w_sreg      = r_sreg;
    w_shadow    = r_shadow;
    w_rb        = r_rb;
    w_img_valid = r_img_valid;
    w_bit       = r_bit;
    w_ser       = r_ser;
    w_chain_err = r_chain_err;
    unique case (r_state)
      S_IDLE: begin
        if (i_clear || r_boot) begin
          w_state  = S_CLEAR;
          w_clr_ph = 1'b0;
          w_boot   = 1'b0;
        end else if (i_load || (AUTO && (i_data != r_shadow))) begin
          w_state = S_LOAD;
        end
      end
      S_CLEAR: begin
        if (w_tick) begin
          if (!r_clr_ph) begin
            w_clr_ph = 1'b1;
          end else begin
            w_state     = S_DONE;
            w_shadow    = '0;
            w_img_valid = 1'b0;
            w_chain_err = 1'b0;
          end
        end
      end
      S_LOAD: begin
        w_img   = i_data;
        w_sreg  = i_data;
        w_ser   = i_data[N_BITS-1];
        w_bit   = '0;
        w_state = S_SH_LO;
      end
      S_SH_LO: begin
        if (w_tick) begin
          w_rb    = {r_rb[N_BITS-2:0], i_ser_ret};
          w_state = S_SH_HI;
        end
      end
      S_SH_HI: begin
        if (w_tick) begin
          if (r_bit == LP_LAST) begin
            w_ser   = 1'b0;
            w_state = S_LATCH;
          end else begin
            w_bit   = r_bit + LP_ONE;
            w_sreg  = {r_sreg[N_BITS-2:0], 1'b0};
            w_ser   = r_sreg[N_BITS-2];
            w_state = S_SH_LO;
          end
        end
      end
      S_LATCH: begin
        if (w_tick) begin
          // r_shadow still holds the image the chain carried before this shift.
          w_chain_err = RB_EN && (r_rb != r_shadow);
          w_shadow    = r_img;
          w_img_valid = 1'b1;
          w_state     = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign w_restart = (w_state != r_state) || (w_clr_ph != r_clr_ph);
  assign w_srclr_n = !((w_state == S_CLEAR) && !w_clr_ph);
  assign w_rclk    = ((w_state == S_CLEAR) && w_clr_ph) || (w_state == S_LATCH);
  assign w_srclk   = (w_state == S_SH_HI);
  assign w_busy    = (w_state != S_IDLE);
  assign w_done    = (w_state == S_DONE);
  assign w_oe_n    = ~(i_oe_en & w_img_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_boot      <= 1'b1;
      r_clr_ph    <= 1'b0;
      r_img       <= '0;
      r_sreg      <= '0;
      r_shadow    <= '0;
      r_rb        <= '0;
      r_img_valid <= 1'b0;
      r_bit       <= '0;
      r_ser       <= 1'b0;
      r_chain_err <= 1'b0;
      o_SRCLR_n   <= 1'b1;
      o_RCLK      <= 1'b0;
      o_SRCLK     <= 1'b0;
      o_busy      <= 1'b1;
      o_done      <= 1'b0;
      o_OE_n      <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_boot      <= w_boot;
      r_clr_ph    <= w_clr_ph;
      r_img       <= w_img;
      r_sreg      <= w_sreg;
      r_shadow    <= w_shadow;
      r_rb        <= w_rb;
      r_img_valid <= w_img_valid;
      r_bit       <= w_bit;
      r_ser       <= w_ser;
      r_chain_err <= w_chain_err;
      o_SRCLR_n   <= w_srclr_n;
      o_RCLK      <= w_rclk;
      o_SRCLK     <= w_srclk;
      o_busy      <= w_busy;
      o_done      <= w_done;
      o_OE_n      <= w_oe_n;
    end
  end

  assign o_SER       = r_ser;
  assign o_chain_err = r_chain_err;

endmodule
